nibble_rx: RTL and testbench

Serial-to-parallel framing receiver that sits directly upstream of the 4-bit enabled register stage. It samples a serial line on a bit strobe, validates start, parity and stop bits, and presents the assembled nibble on d with a one-cycle en pulse. The register captures d on that pulse. Frame errors are flagged, and no en pulse is issued for a bad frame.

---
 rtl/nibble_rx_pkg.sv | 13 +
 rtl/nibble_rx_if.sv | 25 ++
 rtl/nibble_shift.sv | 34 +++
 rtl/nibble_rx.sv | 104 ++++++++++
 tb/tb_nibble_rx.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/nibble_rx_pkg.sv
// Shared types and constants for the nibble_rx serial framing receiver.
package nibble_rx_pkg;

  localparam int DW_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

endpackage

// File: rtl/nibble_rx_if.sv
// Serial-in / parallel-out bus of nibble_rx: strobe + line in, nibble + status pulses out.
interface nibble_rx_if #(
  parameter int DW = 4
) ();

  logic          bit_en;
  logic          sin;
  logic [DW-1:0] d;
  logic          en;
  logic          perr;
  logic          ferr;
  logic          busy;

  // master drives the serial line; slave is the receiver
  modport master (
    output bit_en, sin,
    input  d, en, perr, ferr, busy
  );

  modport slave (
    input  bit_en, sin,
    output d, en, perr, ferr, busy
  );

endinterface

// File: rtl/nibble_shift.sv
// LSB-first insert register: each load writes din at the current bit index and advances it.
module nibble_shift #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic          din,
  output logic [DW-1:0] q,
  output logic          last
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q   <= '0;
      cnt <= '0;
    end else if (clr) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q[cnt] <= din;
      cnt    <= cnt + 1'b1;
    end
  end

  // index wraps back to 0 only on the load that completes the nibble
  assign last = (cnt == CW'(DW - 1));

endmodule

// File: rtl/nibble_rx.sv
// Framing receiver: start, DW data bits LSB first, optional parity, stop; good nibble -> d + en pulse.
//   state | meaning
//   IDLE  | line idle, waiting for a 0 start bit on a strobe
//   DATA  | collecting data bits into the shift register
//   PAR   | sampling the parity bit and latching the parity verdict
//   STOP  | sampling the stop bit, issuing en / perr / ferr
module nibble_rx
  import nibble_rx_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  nibble_rx_if.slave bus
);

  state_t        state;
  logic          par_ok;
  logic [DW-1:0] shreg;
  logic          last;
  logic          shift_clr;
  logic          shift_load;

  logic [DW-1:0] d_q;
  logic          en_q;
  logic          perr_q;
  logic          ferr_q;
  logic          busy_q;

  assign shift_clr  = bus.bit_en && (state == IDLE) && !bus.sin;
  assign shift_load = bus.bit_en && (state == DATA);

  nibble_shift #(
    .DW(DW)
  ) u_shift (
    .clk  (clk),
    .reset(reset),
    .clr  (shift_clr),
    .load (shift_load),
    .din  (bus.sin),
    .q    (shreg),
    .last (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      par_ok <= 1'b1;
      d_q    <= '0;
      en_q   <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      if (bus.bit_en) begin
        case (state)
          IDLE: begin
            if (!bus.sin) begin
              state  <= DATA;
              busy_q <= 1'b1;
              // without a parity bit the verdict stays good for the whole frame
              par_ok <= 1'b1;
            end
          end
          DATA: begin
            if (last) state <= PARITY_EN ? PAR : STOP;
          end
          PAR: begin
            par_ok <= ((^shreg ^ bus.sin) == ODD_PARITY);
            state  <= STOP;
          end
          STOP: begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (bus.sin) begin
              if (par_ok) begin
                d_q  <= shreg;
                en_q <= 1'b1;
              end else begin
                perr_q <= 1'b1;
              end
            end else begin
              ferr_q <= 1'b1;
              perr_q <= !par_ok;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.d    = d_q;
  assign bus.en   = en_q;
  assign bus.perr = perr_q;
  assign bus.ferr = ferr_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_nibble_rx.sv
// Directed bench for nibble_rx: good, parity-error, framing-error, back-to-back, abort and gapped frames.
module tb_nibble_rx;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   en_cnt   = 0;

  nibble_rx_if #(.DW(4)) bus ();

  nibble_rx #(
    .DW(4),
    .PARITY_EN(1'b1),
    .ODD_PARITY(1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.en) en_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // entered at a negedge; returns at the negedge after the sampling posedge
  task automatic strobe(input logic b);
    bus.bit_en = 1'b1;
    bus.sin    = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.bit_en = 1'b0;
    bus.sin    = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] data, input logic par, input logic stp, input int gap);
    strobe(1'b0);
    chk("busy_after_start", bus.busy, 1'b1);
    if (gap > 0) idle(gap);
    for (int i = 0; i < 4; i++) begin
      strobe(data[i]);
      if (gap > 0) idle(gap);
    end
    strobe(par);
    if (gap > 0) idle(gap);
    strobe(stp);
  endtask

  task automatic do_reset();
    bus.bit_en = 1'b0;
    bus.sin    = 1'b1;
    reset      = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  int base;

  initial begin
    bus.bit_en = 1'b0;
    bus.sin    = 1'b1;
    reset      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_d", bus.d, 4'h0);
    chk("rst_en", bus.en, 1'b0);
    chk("rst_perr", bus.perr, 1'b0);
    chk("rst_ferr", bus.ferr, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // 1: good frame 1101 (data 1,0,1,1 has three ones -> parity 1)
    send_frame(4'b1101, 1'b1, 1'b1, 0);
    chk("t1_en", bus.en, 1'b1);
    chk("t1_d", bus.d, 4'b1101);
    chk("t1_perr", bus.perr, 1'b0);
    chk("t1_ferr", bus.ferr, 1'b0);
    chk("t1_busy", bus.busy, 1'b0);
    idle(1);
    chk("t1_en_one_cycle", bus.en, 1'b0);

    // 2: same frame, bad parity
    do_reset();
    send_frame(4'b1101, 1'b0, 1'b1, 0);
    chk("t2_perr", bus.perr, 1'b1);
    chk("t2_en", bus.en, 1'b0);
    chk("t2_ferr", bus.ferr, 1'b0);
    chk("t2_d", bus.d, 4'b0000);
    idle(1);
    chk("t2_perr_one_cycle", bus.perr, 1'b0);

    // 3: good 0011, then framing error, then framing + parity error
    send_frame(4'b0011, 1'b0, 1'b1, 0);
    chk("t3_en", bus.en, 1'b1);
    chk("t3_d", bus.d, 4'b0011);
    idle(1);
    send_frame(4'b1001, 1'b0, 1'b0, 0);
    chk("t3_ferr", bus.ferr, 1'b1);
    chk("t3_ferr_perr", bus.perr, 1'b0);
    chk("t3_ferr_en", bus.en, 1'b0);
    chk("t3_ferr_d", bus.d, 4'b0011);
    idle(1);
    chk("t3_ferr_one_cycle", bus.ferr, 1'b0);
    send_frame(4'b1001, 1'b1, 1'b0, 0);
    chk("t3_both_ferr", bus.ferr, 1'b1);
    chk("t3_both_perr", bus.perr, 1'b1);
    chk("t3_both_en", bus.en, 1'b0);
    chk("t3_both_d", bus.d, 4'b0011);
    idle(1);

    // 4: back-to-back 1010 then 0101, no idle bit
    send_frame(4'b1010, 1'b0, 1'b1, 0);
    chk("t4a_en", bus.en, 1'b1);
    chk("t4a_d", bus.d, 4'b1010);
    send_frame(4'b0101, 1'b0, 1'b1, 0);
    chk("t4b_en", bus.en, 1'b1);
    chk("t4b_d", bus.d, 4'b0101);
    chk("t4b_perr", bus.perr, 1'b0);
    chk("t4b_ferr", bus.ferr, 1'b0);
    idle(1);

    // 5: reset mid-frame after 3 data bits
    base = en_cnt;
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b1);
    chk("t5_busy_mid", bus.busy, 1'b1);
    bus.bit_en = 1'b0;
    #2 reset = 1'b0;
    #1 chk("t5_busy_async", bus.busy, 1'b0);
    chk("t5_d_async", bus.d, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    chk("t5_no_pulse", en_cnt - base, 0);
    send_frame(4'b1111, 1'b0, 1'b1, 0);
    chk("t5_en", bus.en, 1'b1);
    chk("t5_d", bus.d, 4'b1111);
    idle(1);

    // 6: long idle-high line, then a frame with 3-cycle gaps between strobes
    for (int i = 0; i < 10; i++) begin
      strobe(1'b1);
      chk("t6_idle_busy", bus.busy, 1'b0);
    end
    base = en_cnt;
    send_frame(4'b0110, 1'b0, 1'b1, 3);
    chk("t6_en", bus.en, 1'b1);
    chk("t6_d", bus.d, 4'b0110);
    chk("t6_perr", bus.perr, 1'b0);
    chk("t6_ferr", bus.ferr, 1'b0);
    idle(1);
    chk("t6_pulse_count", en_cnt - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
